multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the RV32I subset core: jal, beq, blt, lw, sw, addi.
- Sequences fetch, decode, execute, memory access and writeback around the shared ALU, register file, PC register, IR and immediate generator.
- Handles ready-based handshakes to instruction and data memory, with timeout traps.
- Counts retired instructions.

---
 rtl/rv_ctrl_pkg.sv | 45 ++++
 rtl/ctrl_timeout_cnt.sv | 36 +++
 rtl/multicycle_ctrl.sv | 170 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I-subset multi-cycle control FSM.
// Opcodes, funct3 values, state encoding and output-field encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BLT = 3'b100;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StTrap
  } state_e;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  // Only branches are qualified by funct3; the other supported ops decode on opcode alone.
  function automatic logic is_legal(logic [6:0] op, logic [2:0] f3);
    unique case (op)
      OP_JAL, OP_LOAD, OP_STORE, OP_IMM: return 1'b1;
      OP_BRANCH:                         return (f3 == F3_BEQ) || (f3 == F3_BLT);
      default:                           return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_timeout_cnt.sv
// Wait-cycle counter for memory handshakes; expire_o flags the last
// permitted request cycle (TIMEOUT-th cycle since the count was cleared).
module ctrl_timeout_cnt #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the jal/beq/blt/lw/sw/addi core: sequences
// fetch, decode, execute, memory and writeback, traps on illegal ops or timeouts.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  state_e             state_q, state_d;
  logic [6:0]         op_q, op_d;
  logic [2:0]         f3_q, f3_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               wait_en, wait_clr, expire;

  // Counting only while a request is stalled; any state change restarts it.
  assign wait_en  = ((state_q == StFetch) && !imem_ready) || ((state_q == StMem) && !dmem_ready);
  assign wait_clr = (state_d != state_q);

  ctrl_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .expire_o (expire)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    f3_d    = f3_q;
    cause_d = cause_q;
    unique case (state_q)
      StIdle:  state_d = StFetch;
      StFetch: begin
        if (imem_ready) begin
          state_d = StDecode;
        end else if (expire) begin
          state_d = StTrap;
          cause_d = CAUSE_IMEM;
        end
      end
      StDecode: begin
        op_d = opcode;
        f3_d = funct3;
        if (is_legal(opcode, funct3)) begin
          state_d = StExec;
        end else begin
          state_d = StTrap;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      StExec: begin
        case (op_q)
          OP_IMM:            state_d = StWb;
          OP_LOAD, OP_STORE: state_d = StMem;
          default:           state_d = StFetch;
        endcase
      end
      StMem: begin
        if (dmem_ready) begin
          state_d = (op_q == OP_STORE) ? StFetch : StWb;
        end else if (expire) begin
          state_d = StTrap;
          cause_d = CAUSE_DMEM;
        end
      end
      StWb:    state_d = StFetch;
      StTrap:  state_d = StTrap;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    reg_we   = 1'b0;
    pc_we    = 1'b0;
    pc_src   = 1'b0;
    alu_src  = 1'b0;
    alu_op   = ALU_ADD;
    wb_sel   = WB_ALU;
    trap     = 1'b0;
    unique case (state_q)
      StFetch: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
      end
      StExec: begin
        case (op_q)
          OP_IMM, OP_LOAD, OP_STORE: alu_src = 1'b1;
          OP_BRANCH: begin
            alu_op = ALU_SUB;
            pc_we  = 1'b1;
            pc_src = (f3_q == F3_BEQ) ? alu_zero : alu_lt;
          end
          OP_JAL: begin
            reg_we = 1'b1;
            wb_sel = WB_PC4;
            pc_we  = 1'b1;
            pc_src = 1'b1;
          end
          default: ;
        endcase
      end
      StMem: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        pc_we    = dmem_ready && (op_q == OP_STORE);
      end
      StWb: begin
        reg_we = 1'b1;
        wb_sel = (op_q == OP_LOAD) ? WB_MEM : WB_ALU;
        pc_we  = 1'b1;
      end
      StTrap:  trap = 1'b1;
      default: ;
    endcase
  end

  // Every PC update marks one retired instruction.
  assign retired_d = retired_q + CNT_W'(pc_we);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      f3_q      <= '0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      f3_q      <= f3_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  assign trap_cause = cause_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: expected per-cycle control vectors are
// queued by the stimulus and popped by a monitor whenever any control is active.
module tb_multicycle_ctrl;
  import rv_ctrl_pkg::*;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_we;
    logic       pc_we;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_op;
    logic [1:0] wb_sel;
    logic       trap;
    logic [1:0] trap_cause;
  } ctl_t;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] retired;
    ctl_t        ctl;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic alu_zero, alu_lt, imem_ready, dmem_ready;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src, alu_src, trap;
  logic [1:0] alu_op, wb_sel, trap_cause;
  logic [31:0] retired;
  logic u4_imem_req, u4_ir_we, u4_dmem_req, u4_dmem_we, u4_reg_we, u4_pc_we, u4_pc_src;
  logic u4_alu_src, u4_trap;
  logic [1:0] u4_alu_op, u4_wb_sel, u4_trap_cause;
  logic [31:0] u4_retired;

  always #5 clk = ~clk;

  multicycle_ctrl u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_we(reg_we), .pc_we(pc_we),
    .pc_src(pc_src), .alu_src(alu_src), .alu_op(alu_op), .wb_sel(wb_sel), .trap(trap),
    .trap_cause(trap_cause), .retired(retired)
  );

  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .alu_zero(alu_zero),
    .alu_lt(alu_lt), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(u4_imem_req), .ir_we(u4_ir_we), .dmem_req(u4_dmem_req), .dmem_we(u4_dmem_we),
    .reg_we(u4_reg_we), .pc_we(u4_pc_we), .pc_src(u4_pc_src), .alu_src(u4_alu_src),
    .alu_op(u4_alu_op), .wb_sel(u4_wb_sel), .trap(u4_trap), .trap_cause(u4_trap_cause),
    .retired(u4_retired)
  );

  obs_t q[$];
  int total = 0;
  int bad = 0;
  int unsigned c, r, cyc;
  int imem_lat, dmem_lat;
  logic [6:0] p_op[8];
  logic [2:0] p_f3[8];
  logic       p_z[8];
  logic       p_lt[8];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic obs_t sample();
    obs_t o;
    o.cyc     = cyc;
    o.retired = retired;
    o.ctl     = '{imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src, alu_src,
                  alu_op, wb_sel, trap, trap_cause};
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // IR model: the next program word appears once the fetch is accepted.
  initial begin
    int idx;
    idx = 0; opcode = '0; funct3 = '0; alu_zero = 1'b0; alu_lt = 1'b0;
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) begin
        idx = 0;
      end else if (ir_we && idx < 8) begin
        opcode = p_op[idx]; funct3 = p_f3[idx]; alu_zero = p_z[idx]; alu_lt = p_lt[idx];
        idx++;
      end
    end
  end

  // Memory model: ready after imem_lat/dmem_lat stalled request cycles; -1 never answers.
  initial begin
    int icnt, dcnt;
    icnt = 0; dcnt = 0; imem_ready = 1'b0; dmem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_req) begin
        icnt++;
        imem_ready = (imem_lat >= 0) && (icnt > imem_lat);
      end else begin
        icnt = 0; imem_ready = 1'b0;
      end
      if (dmem_req) begin
        dcnt++;
        dmem_ready = (dmem_lat >= 0) && (dcnt > dmem_lat);
      end else begin
        dcnt = 0; dmem_ready = 1'b0;
      end
    end
  end

  // Monitor: compares every cycle with any control asserted against the queue head.
  initial begin
    obs_t a, e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        a = sample();
        if (a.ctl != '0) begin
          total++;
          if (q.size() == 0) begin
            bad++;
            $display("FAIL unexpected: cyc=%0d ret=%0d ctl=%h with nothing expected",
                     a.cyc, a.retired, a.ctl);
          end else begin
            e = q.pop_front();
            if (a !== e) begin
              bad++;
              $display("FAIL scoreboard: got cyc=%0d ret=%0d ctl=%h expected cyc=%0d ret=%0d ctl=%h",
                       a.cyc, a.retired, a.ctl, e.cyc, e.retired, e.ctl);
            end
          end
        end
      end
    end
  end

  task automatic push(input ctl_t v);
    obs_t o;
    o.cyc = c; o.retired = r; o.ctl = v;
    q.push_back(o);
    c++;
  endtask

  task automatic e_req(input int n);
    ctl_t v;
    for (int i = 0; i < n; i++) begin
      v = '0; v.imem_req = 1'b1; push(v);
    end
  endtask

  task automatic e_fetch(input int lat);
    ctl_t v;
    e_req(lat);
    v = '0; v.imem_req = 1'b1; v.ir_we = 1'b1; push(v);
    c++;  // decode cycle drives nothing
  endtask

  task automatic e_addr();
    ctl_t v;
    v = '0; v.alu_src = 1'b1; push(v);
  endtask

  task automatic e_mem(input bit we, input int waits, input bit done);
    ctl_t v;
    for (int i = 0; i < waits; i++) begin
      v = '0; v.dmem_req = 1'b1; v.dmem_we = we; push(v);
    end
    if (done) begin
      v = '0; v.dmem_req = 1'b1; v.dmem_we = we; v.pc_we = we; push(v);
      if (we) r++;
    end
  endtask

  task automatic e_wb(input bit lw);
    ctl_t v;
    v = '0; v.reg_we = 1'b1; v.pc_we = 1'b1; v.wb_sel = lw ? 2'b01 : 2'b00; push(v);
    r++;
  endtask

  task automatic e_branch(input bit taken);
    ctl_t v;
    v = '0; v.alu_op = 2'b01; v.pc_we = 1'b1; v.pc_src = taken; push(v);
    r++;
  endtask

  task automatic e_jal();
    ctl_t v;
    v = '0; v.reg_we = 1'b1; v.wb_sel = 2'b10; v.pc_we = 1'b1; v.pc_src = 1'b1; push(v);
    r++;
  endtask

  task automatic e_trap(input logic [1:0] cause, input int n);
    ctl_t v;
    for (int i = 0; i < n; i++) begin
      v = '0; v.trap = 1'b1; v.trap_cause = cause; push(v);
    end
  endtask

  task automatic prog(input int i, input logic [6:0] op, input logic [2:0] f3,
                      input logic z, input logic lt);
    p_op[i] = op; p_f3[i] = f3; p_z[i] = z; p_lt[i] = lt;
  endtask

  task automatic begin_test(input int il, input int dl);
    ctl_t z;
    rst_n = 1'b0;
    #1;
    z = sample().ctl;
    chk("reset_ctl", 64'(z), 64'd0);
    chk("reset_retired", 64'(retired), 64'd0);
    imem_lat = il; dmem_lat = dl; c = 1; r = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name, input int limit);
    int n;
    n = 0;
    while (q.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d expected vectors left after %0d cycles", name, q.size(), n);
      q.delete();
    end
    #1;
  endtask

  initial begin
    ctl_t z;
    rst_n = 1'b1; imem_lat = 0; dmem_lat = 0;
    for (int i = 0; i < 8; i++) prog(i, OP_IMM, 3'b000, 1'b0, 1'b0);
    #1;

    prog(0, OP_IMM, 3'b000, 1'b0, 1'b0);
    begin_test(0, 0);
    e_fetch(0); e_addr(); e_wb(1'b0);
    drain("addi", 20);
    chk("addi_retired", 64'(retired), 64'd1);

    prog(0, OP_BRANCH, F3_BEQ, 1'b1, 1'b0);
    prog(1, OP_BRANCH, F3_BEQ, 1'b0, 1'b1);
    prog(2, OP_BRANCH, F3_BLT, 1'b0, 1'b1);
    prog(3, OP_BRANCH, F3_BLT, 1'b1, 1'b0);
    begin_test(0, 0);
    e_fetch(0); e_branch(1'b1);
    e_fetch(0); e_branch(1'b0);
    e_fetch(0); e_branch(1'b1);
    e_fetch(0); e_branch(1'b0);
    drain("branch", 40);
    chk("branch_retired", 64'(retired), 64'd4);

    prog(0, OP_LOAD, 3'b010, 1'b0, 1'b0);
    begin_test(0, 3);
    e_fetch(0); e_addr(); e_mem(1'b0, 3, 1'b1); e_wb(1'b1);
    drain("lw", 30);
    chk("lw_retired", 64'(retired), 64'd1);

    prog(0, OP_STORE, 3'b010, 1'b0, 1'b0);
    prog(1, OP_JAL, 3'b000, 1'b0, 1'b0);
    begin_test(0, 0);
    e_fetch(0); e_addr(); e_mem(1'b1, 0, 1'b1);
    e_fetch(0); e_jal();
    drain("sw_jal", 30);
    chk("sw_jal_retired", 64'(retired), 64'd2);

    prog(0, 7'b0110111, 3'b000, 1'b0, 1'b0);
    begin_test(0, 0);
    e_fetch(0); e_trap(CAUSE_ILLEGAL, 3);
    drain("illegal", 20);
    chk("illegal_cause", 64'(trap_cause), 64'd1);

    prog(0, OP_BRANCH, 3'b001, 1'b0, 1'b0);
    begin_test(0, 0);
    e_fetch(0); e_trap(CAUSE_ILLEGAL, 1);
    drain("bad_f3", 20);

    prog(0, OP_IMM, 3'b000, 1'b0, 1'b0);
    begin_test(-1, 0);
    e_req(16); e_trap(CAUSE_IMEM, 3);
    drain("imem_to", 40);
    chk("imem_to_retired", 64'(retired), 64'd0);

    begin_test(15, 0);
    e_fetch(15); e_addr(); e_wb(1'b0);
    drain("imem_edge", 40);
    chk("imem_edge_retired", 64'(retired), 64'd1);
    chk("t4_trap_late", 64'(u4_trap), 64'd1);
    chk("t4_cause_late", 64'(u4_trap_cause), 64'd2);

    begin_test(3, 0);
    e_fetch(3); e_addr(); e_wb(1'b0);
    drain("imem_lat3", 30);
    chk("t4_no_trap", 64'(u4_trap), 64'd0);
    chk("t4_retired", 64'(u4_retired), 64'd1);

    prog(0, OP_LOAD, 3'b010, 1'b0, 1'b0);
    begin_test(0, -1);
    e_fetch(0); e_addr(); e_mem(1'b0, 16, 1'b0); e_trap(CAUSE_DMEM, 2);
    drain("dmem_to", 40);

    prog(0, OP_IMM, 3'b000, 1'b0, 1'b0);
    prog(1, OP_LOAD, 3'b010, 1'b0, 1'b0);
    begin_test(0, -1);
    e_fetch(0); e_addr(); e_wb(1'b0);
    e_fetch(0); e_addr(); e_mem(1'b0, 2, 1'b0);
    drain("pre_reset", 30);
    chk("pre_reset_retired", 64'(retired), 64'd1);
    rst_n = 1'b0;
    #1;
    z = sample().ctl;
    chk("midreset_ctl", 64'(z), 64'd0);
    chk("midreset_retired", 64'(retired), 64'd0);
    imem_lat = -1; c = 1; r = 0;
    e_req(1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    z = sample().ctl;
    chk("idle_ctl", 64'(z), 64'd0);
    drain("post_reset", 10);
    rst_n = 1'b0;
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
